// File: rtl/qei_pkg.sv
// Shared quadrature decoder definitions: Gray-code states, step codes and the
// transition classifier used by every channel.
package qei_pkg;

  typedef logic [1:0] qstate_t;
  typedef logic [1:0] step_t;

  // Quadrature states as {B, A}, listed in the forward (+1) order.
  localparam qstate_t S00 = 2'b00;
  localparam qstate_t S01 = 2'b01;
  localparam qstate_t S11 = 2'b11;
  localparam qstate_t S10 = 2'b10;

  localparam step_t STEP_NONE = 2'd0;
  localparam step_t STEP_UP   = 2'd1;
  localparam step_t STEP_DN   = 2'd2;
  localparam step_t STEP_ERR  = 2'd3;

  function automatic step_t qei_decode(input qstate_t prev, input qstate_t cur);
    step_t step;
    step = STEP_NONE;
    if (prev == cur) begin
      step = STEP_NONE;
    end else if ((prev ^ cur) == 2'b11) begin
      step = STEP_ERR;
    end else begin
      case ({prev, cur})
        {S00, S01}, {S01, S11}, {S11, S10}, {S10, S00}: step = STEP_UP;
        default:                                        step = STEP_DN;
      endcase
    end
    return step;
  endfunction

endpackage

// File: rtl/qei_multi_if.sv
// Bundle of encoder pins, per-channel controls and counter readout for qei_multi.
interface qei_multi_if #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CNT_W  = 32
);

  logic [CH_NUM-1:0]       PHASE_A;
  logic [CH_NUM-1:0]       PHASE_B;
  logic [CH_NUM-1:0]       PHASE_Z;
  logic [CH_NUM-1:0]       CLEAR;
  logic [CH_NUM-1:0]       IDX_CLR_EN;
  logic [CH_NUM-1:0]       DIR_INV;
  logic [CH_NUM-1:0]       ERR_CLR;
  logic                    SNAP;
  logic [CH_NUM*CNT_W-1:0] CNT_OUT;
  logic [CH_NUM*CNT_W-1:0] SNAP_OUT;
  logic [CH_NUM-1:0]       DIR_OUT;
  logic [CH_NUM-1:0]       ERR_OUT;

  modport master (
    output PHASE_A, PHASE_B, PHASE_Z, CLEAR, IDX_CLR_EN, DIR_INV, ERR_CLR, SNAP,
    input  CNT_OUT, SNAP_OUT, DIR_OUT, ERR_OUT
  );

  modport slave (
    input  PHASE_A, PHASE_B, PHASE_Z, CLEAR, IDX_CLR_EN, DIR_INV, ERR_CLR, SNAP,
    output CNT_OUT, SNAP_OUT, DIR_OUT, ERR_OUT
  );

endinterface

// File: rtl/qei_filter.sv
// One-bit 2-flop synchroniser followed by a run-length glitch filter; while
// settle_i is high the filtered value tracks the synchronised value directly.
module qei_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic settle_i,
  input  logic async_i,
  output logic filt_o
);

  localparam logic [3:0] RunLast = 4'(FILT_LEN - 1);

  logic       sync1_q, sync2_q;
  logic       filt_q, filt_d;
  logic [3:0] run_q, run_d;

  always_comb begin
    filt_d = filt_q;
    run_d  = '0;
    if (settle_i) begin
      filt_d = sync2_q;
    end else if (sync2_q != filt_q) begin
      // Follow only after FILT_LEN consecutive differing samples.
      if (run_q == RunLast) begin
        filt_d = sync2_q;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      run_q   <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      run_q   <= run_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/qei_multi.sv
// Multi-channel x4 quadrature decoder: filtered inputs, wrapping counters with
// clear/index reset, direction and sticky error flags, coherent snapshot.
module qei_multi #(
  parameter int unsigned CH_NUM   = 4,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        CLK,
  input  logic        RST_n,
  qei_multi_if.slave  bus
);
  import qei_pkg::*;

  localparam logic [4:0] SettleLen = 5'(2 + FILT_LEN);

  logic [4:0] settle_cnt_q;
  logic       settle;

  logic [CH_NUM-1:0] filt_a, filt_b, filt_z;

  logic [CH_NUM-1:0][1:0]       prev_q;
  logic [CH_NUM-1:0]            z_prev_q;
  logic [CH_NUM-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CH_NUM-1:0][CNT_W-1:0] snap_q;
  logic [CH_NUM-1:0]            dir_q, dir_d;
  logic [CH_NUM-1:0]            err_q, err_d;
  logic [CH_NUM-1:0][1:0]       cur;
  logic [CH_NUM-1:0][1:0]       step;
  logic [CH_NUM-1:0]            idx_hit;

  // Inputs settle through sync and filter before any decoding is trusted.
  assign settle = (settle_cnt_q != SettleLen);

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      settle_cnt_q <= '0;
    end else if (settle) begin
      settle_cnt_q <= settle_cnt_q + 5'd1;
    end
  end

  for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
    qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_a (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .settle_i (settle),
      .async_i  (bus.PHASE_A[i]),
      .filt_o   (filt_a[i])
    );
    qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_b (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .settle_i (settle),
      .async_i  (bus.PHASE_B[i]),
      .filt_o   (filt_b[i])
    );
    qei_filter #(.FILT_LEN(FILT_LEN)) u_filt_z (
      .CLK      (CLK),
      .RST_n    (RST_n),
      .settle_i (settle),
      .async_i  (bus.PHASE_Z[i]),
      .filt_o   (filt_z[i])
    );
  end

  always_comb begin
    cur     = '0;
    step    = '0;
    idx_hit = '0;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    err_d   = err_q;
    for (int i = 0; i < CH_NUM; i++) begin
      cur[i]  = {filt_b[i], filt_a[i]};
      step[i] = settle ? STEP_NONE : qei_decode(prev_q[i], cur[i]);
      if (bus.DIR_INV[i]) begin
        if (step[i] == STEP_UP) begin
          step[i] = STEP_DN;
        end else if (step[i] == STEP_DN) begin
          step[i] = STEP_UP;
        end
      end
      idx_hit[i] = !settle && bus.IDX_CLR_EN[i] && filt_z[i] && !z_prev_q[i];

      // Direction follows every valid step, even ones the counter discards.
      if (step[i] == STEP_UP) begin
        dir_d[i] = 1'b1;
      end else if (step[i] == STEP_DN) begin
        dir_d[i] = 1'b0;
      end

      if (bus.CLEAR[i] || idx_hit[i]) begin
        cnt_d[i] = '0;
      end else if (step[i] == STEP_UP) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else if (step[i] == STEP_DN) begin
        cnt_d[i] = cnt_q[i] - CNT_W'(1);
      end

      if (step[i] == STEP_ERR) begin
        err_d[i] = 1'b1;
      end else if (bus.ERR_CLR[i]) begin
        err_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      prev_q   <= '0;
      z_prev_q <= '0;
      cnt_q    <= '0;
      snap_q   <= '0;
      dir_q    <= '0;
      err_q    <= '0;
    end else begin
      prev_q   <= cur;
      z_prev_q <= filt_z;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      err_q    <= err_d;
      if (bus.SNAP) begin
        snap_q <= cnt_q;
      end
    end
  end

  assign bus.CNT_OUT  = cnt_q;
  assign bus.SNAP_OUT = snap_q;
  assign bus.DIR_OUT  = dir_q;
  assign bus.ERR_OUT  = err_q;

endmodule

// File: tb/tb_qei_multi.sv
// Directed bench for qei_multi at default parameters; each task drives one
// scenario and compares against hand-computed values.
module tb_qei_multi;

  localparam int unsigned CH_NUM   = 4;
  localparam int unsigned CNT_W    = 32;
  localparam int unsigned FILT_LEN = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  qei_multi_if #(.CH_NUM(CH_NUM), .CNT_W(CNT_W)) bus ();

  qei_multi #(.CH_NUM(CH_NUM), .CNT_W(CNT_W), .FILT_LEN(FILT_LEN)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] cnt(input int ch);
    return bus.CNT_OUT[ch*32 +: 32];
  endfunction

  function automatic logic [31:0] snp(input int ch);
    return bus.SNAP_OUT[ch*32 +: 32];
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n          = 1'b0;
    bus.PHASE_A    = '0;
    bus.PHASE_B    = '0;
    bus.PHASE_Z    = '0;
    bus.CLEAR      = '0;
    bus.IDX_CLR_EN = '0;
    bus.DIR_INV    = '0;
    bus.ERR_CLR    = '0;
    bus.SNAP       = 1'b0;
    wait_cyc(3);
    checks++; if (bus.CNT_OUT !== '0) begin errors++;
      $display("FAIL rst_cnt: got %h expected 0", bus.CNT_OUT); end
    checks++; if (bus.SNAP_OUT !== '0) begin errors++;
      $display("FAIL rst_snap: got %h expected 0", bus.SNAP_OUT); end
    checks++; if (bus.DIR_OUT !== 4'h0) begin errors++;
      $display("FAIL rst_dir: got %h expected 0", bus.DIR_OUT); end
    checks++; if (bus.ERR_OUT !== 4'h0) begin errors++;
      $display("FAIL rst_err: got %h expected 0", bus.ERR_OUT); end
    rst_n = 1'b1;
    wait_cyc(10);
    checks++; if (bus.CNT_OUT !== '0 || bus.ERR_OUT !== 4'h0) begin errors++;
      $display("FAIL post_rst: got cnt=%h err=%h expected 0", bus.CNT_OUT, bus.ERR_OUT); end
  endtask

  task automatic test_forward();
    bus.PHASE_A[0] = 1'b1;
    wait_cyc(5);
    checks++; if (cnt(0) !== 32'd0) begin errors++;
      $display("FAIL latency_early: got %h expected 0", cnt(0)); end
    wait_cyc(1);
    checks++; if (cnt(0) !== 32'd1) begin errors++;
      $display("FAIL latency_6: got %h expected 1", cnt(0)); end
    wait_cyc(4);
    bus.PHASE_B[0] = 1'b1; wait_cyc(10);
    bus.PHASE_A[0] = 1'b0; wait_cyc(10);
    bus.PHASE_B[0] = 1'b0; wait_cyc(10);
    checks++; if (cnt(0) !== 32'd4) begin errors++;
      $display("FAIL fwd_cnt: got %h expected 4", cnt(0)); end
    checks++; if (bus.DIR_OUT[0] !== 1'b1) begin errors++;
      $display("FAIL fwd_dir: got %b expected 1", bus.DIR_OUT[0]); end
    checks++; if (bus.CNT_OUT[127:32] !== 96'd0) begin errors++;
      $display("FAIL fwd_others: got %h expected 0", bus.CNT_OUT[127:32]); end
  endtask

  task automatic test_reverse();
    bus.PHASE_B[1] = 1'b1;
    wait_cyc(10);
    checks++; if (cnt(1) !== 32'hFFFF_FFFF) begin errors++;
      $display("FAIL rev_wrap: got %h expected ffffffff", cnt(1)); end
    checks++; if (bus.DIR_OUT[1] !== 1'b0) begin errors++;
      $display("FAIL rev_dir: got %b expected 0", bus.DIR_OUT[1]); end
    // Return to 00 under CLEAR so the counter restarts from 0.
    bus.CLEAR[1]   = 1'b1;
    bus.PHASE_B[1] = 1'b0;
    wait_cyc(10);
    bus.CLEAR[1]   = 1'b0;
    bus.DIR_INV[1] = 1'b1;
    wait_cyc(2);
    bus.PHASE_B[1] = 1'b1;
    wait_cyc(10);
    checks++; if (cnt(1) !== 32'd1) begin errors++;
      $display("FAIL inv_cnt: got %h expected 1", cnt(1)); end
    checks++; if (bus.DIR_OUT[1] !== 1'b1) begin errors++;
      $display("FAIL inv_dir: got %b expected 1", bus.DIR_OUT[1]); end
  endtask

  task automatic test_glitch();
    bus.PHASE_A[2] = 1'b1;
    wait_cyc(2);
    bus.PHASE_A[2] = 1'b0;
    wait_cyc(10);
    checks++; if (cnt(2) !== 32'd0 || bus.DIR_OUT[2] !== 1'b0) begin errors++;
      $display("FAIL glitch2: got cnt=%h dir=%b expected 0/0", cnt(2), bus.DIR_OUT[2]); end
    bus.PHASE_A[2] = 1'b1;
    wait_cyc(3);
    bus.PHASE_A[2] = 1'b0;
    wait_cyc(3);
    checks++; if (cnt(2) !== 32'd1) begin errors++;
      $display("FAIL glitch3_up: got %h expected 1", cnt(2)); end
    wait_cyc(10);
    checks++; if (cnt(2) !== 32'd0 || bus.DIR_OUT[2] !== 1'b0) begin errors++;
      $display("FAIL glitch3_net: got cnt=%h dir=%b expected 0/0", cnt(2), bus.DIR_OUT[2]); end
  endtask

  task automatic test_error();
    bus.PHASE_A[3] = 1'b1;
    bus.PHASE_B[3] = 1'b1;
    wait_cyc(10);
    checks++; if (bus.ERR_OUT[3] !== 1'b1) begin errors++;
      $display("FAIL err_set: got %b expected 1", bus.ERR_OUT[3]); end
    checks++; if (cnt(3) !== 32'd0) begin errors++;
      $display("FAIL err_cnt: got %h expected 0", cnt(3)); end
    bus.ERR_CLR[3] = 1'b1;
    wait_cyc(1);
    bus.ERR_CLR[3] = 1'b0;
    wait_cyc(1);
    checks++; if (bus.ERR_OUT[3] !== 1'b0) begin errors++;
      $display("FAIL err_clr: got %b expected 0", bus.ERR_OUT[3]); end
    // New error reaches the decoder on the 6th edge; ERR_CLR spans exactly that edge.
    bus.PHASE_A[3] = 1'b0;
    bus.PHASE_B[3] = 1'b0;
    wait_cyc(5);
    bus.ERR_CLR[3] = 1'b1;
    wait_cyc(1);
    bus.ERR_CLR[3] = 1'b0;
    checks++; if (bus.ERR_OUT[3] !== 1'b1) begin errors++;
      $display("FAIL err_set_wins: got %b expected 1", bus.ERR_OUT[3]); end
    checks++; if (cnt(3) !== 32'd0) begin errors++;
      $display("FAIL err_cnt2: got %h expected 0", cnt(3)); end
    wait_cyc(4);
    bus.ERR_CLR[3] = 1'b1;
    wait_cyc(1);
    bus.ERR_CLR[3] = 1'b0;
  endtask

  task automatic test_index_clear();
    // ch0 at 4 in state 00; one step to 5 (state 01).
    bus.PHASE_A[0] = 1'b1; wait_cyc(10);
    bus.PHASE_Z[0] = 1'b1;
    bus.PHASE_B[0] = 1'b1; wait_cyc(10);
    checks++; if (cnt(0) !== 32'd6) begin errors++;
      $display("FAIL idx_disabled: got %h expected 6", cnt(0)); end
    bus.PHASE_Z[0] = 1'b0;
    bus.PHASE_B[0] = 1'b0; wait_cyc(10);
    bus.IDX_CLR_EN[0] = 1'b1;
    wait_cyc(2);
    bus.PHASE_Z[0] = 1'b1;
    bus.PHASE_B[0] = 1'b1; wait_cyc(10);
    checks++; if (cnt(0) !== 32'd0) begin errors++;
      $display("FAIL idx_clear: got %h expected 0", cnt(0)); end
    bus.PHASE_Z[0] = 1'b0; wait_cyc(10);
    bus.IDX_CLR_EN[0] = 1'b0;
    bus.CLEAR[0] = 1'b1;
    bus.PHASE_A[0] = 1'b0; wait_cyc(10);
    checks++; if (cnt(0) !== 32'd0) begin errors++;
      $display("FAIL clear_mid: got %h expected 0", cnt(0)); end
    bus.PHASE_B[0] = 1'b0; wait_cyc(10);
    bus.CLEAR[0] = 1'b0;
    wait_cyc(2);
    checks++; if (cnt(0) !== 32'd0) begin errors++;
      $display("FAIL clear_end: got %h expected 0", cnt(0)); end
  endtask

  task automatic test_snapshot();
    logic [1:0] seq [7];
    seq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10};
    for (int k = 0; k < 7; k++) begin
      bus.PHASE_B[0] = seq[k][1];
      bus.PHASE_A[0] = seq[k][0];
      wait_cyc(10);
    end
    bus.PHASE_B[0] = 1'b0;
    wait_cyc(5);
    bus.SNAP = 1'b1;
    wait_cyc(1);
    bus.SNAP = 1'b0;
    checks++; if (snp(0) !== 32'd7) begin errors++;
      $display("FAIL snap_pre: got %h expected 7", snp(0)); end
    checks++; if (cnt(0) !== 32'd8) begin errors++;
      $display("FAIL snap_live: got %h expected 8", cnt(0)); end
    checks++; if (snp(1) !== 32'd1 || snp(2) !== 32'd0) begin errors++;
      $display("FAIL snap_ch12: got %h/%h expected 1/0", snp(1), snp(2)); end
    bus.PHASE_A[0] = 1'b1;
    wait_cyc(10);
    checks++; if (snp(0) !== 32'd7 || cnt(0) !== 32'd9) begin errors++;
      $display("FAIL snap_hold: got snap=%h cnt=%h expected 7/9", snp(0), cnt(0)); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.CNT_OUT !== '0 || bus.SNAP_OUT !== '0) begin errors++;
      $display("FAIL async_rst_cnt: got cnt=%h snap=%h expected 0", bus.CNT_OUT, bus.SNAP_OUT); end
    checks++; if (bus.DIR_OUT !== 4'h0 || bus.ERR_OUT !== 4'h0) begin errors++;
      $display("FAIL async_rst_flags: got dir=%h err=%h expected 0", bus.DIR_OUT, bus.ERR_OUT); end
    bus.PHASE_A = '1;
    bus.PHASE_B = '1;
    bus.DIR_INV = '0;
    wait_cyc(3);
    rst_n = 1'b1;
    wait_cyc(20);
    checks++; if (bus.ERR_OUT !== 4'h0) begin errors++;
      $display("FAIL settle_err: got %h expected 0", bus.ERR_OUT); end
    checks++; if (bus.CNT_OUT !== '0) begin errors++;
      $display("FAIL settle_cnt: got %h expected 0", bus.CNT_OUT); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_error();
    test_index_clear();
    test_snapshot();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
